// File: rtl/pattern_pkg.sv
// Shared types and reset defaults for the pattern-scan controller and its matcher.
package pattern_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam int         MATCH_CNT_W = 16;
  localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;
  localparam logic [3:0] DEF_LEN     = 4'd4;
  localparam logic       DEF_OVERLAP = 1'b1;

  function automatic logic [MATCH_CNT_W-1:0] sat_inc(input logic [MATCH_CNT_W-1:0] v);
    return (v == '1) ? v : v + MATCH_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pattern_match_shift.sv
// Serial pattern matcher: bit history, saturating fill counter and masked compare.
module pattern_match_shift
  import pattern_pkg::*;
#(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_q, hist_d, hist_shift, mask;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic              hit;

  always_comb begin
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(cfg_len));
    end
    hist_shift = {hist_q[PAT_W-2:0], bit_in};
    fill_inc   = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
    hit        = bit_valid && (int'(fill_inc) >= int'(cfg_len)) &&
                 ((hist_shift & mask) == (cfg_pattern & mask));
    hist_d     = hist_q;
    fill_d     = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_valid) begin
      hist_d = hist_shift;
      // Non-overlapping mode forgets the bits that formed the match.
      fill_d = (hit && !cfg_overlap) ? '0 : fill_inc;
    end
  end

  assign match = hit && !clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word serializer with handshake, run-time pattern configuration, match counting
// and a sticky threshold interrupt.
module pattern_scan_ctrl
  import pattern_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 8,
  parameter int CNT_W  = MATCH_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_threshold,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              irq,
  input  logic              irq_clr,
  output logic              busy,
  output logic              cfg_err
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [3:0]        len_q, len_d;
  logic              overlap_q, overlap_d;
  logic [CNT_W-1:0]  threshold_q, threshold_d;
  logic [CNT_W-1:0]  count_q, count_d, count_inc;
  logic              match_pulse_q, match_pulse_d;
  logic              irq_q, irq_d;
  logic              cfg_err_q, cfg_err_d;
  logic              hs, cfg_ok, hit, irq_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  assign hs = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = SHIFT;
          idx_d   = IDX_W'(DATA_W - 1);
          shreg_d = in_data;
        end
      end
      SHIFT: begin
        if (idx_q != '0) begin
          idx_d = idx_q - IDX_W'(1);
        end else if (hs) begin
          idx_d   = IDX_W'(DATA_W - 1);
          shreg_d = in_data;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces the handshake and serial outputs low regardless of state.
  always_comb begin
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    busy      = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: in_ready = 1'b1;
        SHIFT: begin
          busy      = 1'b1;
          ser_valid = 1'b1;
          ser_bit   = shreg_q[idx_q];
          in_ready  = (idx_q == '0);
        end
        default: in_ready = 1'b0;
      endcase
    end
  end

  pattern_match_shift #(.PAT_W(PAT_W)) u_match (
    .clk         (clk),
    .reset       (reset),
    .clear       (cfg_ok),
    .bit_in      (ser_bit),
    .bit_valid   (ser_valid),
    .cfg_pattern (pattern_q),
    .cfg_len     (len_q),
    .cfg_overlap (overlap_q),
    .match       (hit)
  );

  always_comb begin
    cfg_ok = cfg_we && (state_q == IDLE) && !hs &&
             (cfg_len != 4'd0) && (cfg_len <= 4'(PAT_W));
    cfg_err_d   = cfg_we && !cfg_ok;
    pattern_d   = pattern_q;
    len_d       = len_q;
    overlap_d   = overlap_q;
    threshold_d = threshold_q;
    if (cfg_ok) begin
      pattern_d   = cfg_pattern;
      len_d       = cfg_len;
      overlap_d   = cfg_overlap;
      threshold_d = cfg_threshold;
    end
    count_inc     = sat_inc(count_q);
    irq_set       = hit && (count_q != '1) && (threshold_q != '0) &&
                    (count_inc >= threshold_q);
    match_pulse_d = hit;
    count_d       = count_q;
    irq_d         = irq_q;
    if (cfg_ok) begin
      count_d = '0;
      irq_d   = 1'b0;
    end else begin
      if (hit) count_d = count_inc;
      if (irq_set)      irq_d = 1'b1;
      else if (irq_clr) irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q     <= PAT_W'(DEF_PATTERN);
      len_q         <= DEF_LEN;
      overlap_q     <= DEF_OVERLAP;
      threshold_q   <= '0;
      count_q       <= '0;
      match_pulse_q <= 1'b0;
      irq_q         <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      pattern_q     <= pattern_d;
      len_q         <= len_d;
      overlap_q     <= overlap_d;
      threshold_q   <= threshold_d;
      count_q       <= count_d;
      match_pulse_q <= match_pulse_d;
      irq_q         <= irq_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign match_pulse = match_pulse_q;
  assign match_count = count_q;
  assign irq         = irq_q;
  assign cfg_err     = cfg_err_q;

endmodule
